// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Holds the fetch FSM states, the op field bounds and the opcode values.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_t;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter: reset load, sequential +4 step, redirect load.
// A redirect load takes priority over the sequential step.
module ifu_pc_reg
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] loadAddr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= loadAddr;
        end else if (inc) begin
            pc <= pc + ADDR_W'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: one outstanding imem request, redirect with stale-response kill.
// Define IFU_STALL_CNT_EN to add the stall_cycles decode-backpressure counter.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        op,
`ifdef IFU_STALL_CNT_EN
    output logic [31:0]       stall_cycles,
`endif
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    ifu_state_t        state;
    ifu_state_t        stateNext;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              kill;
    logic              killSet;
    logic              killClr;
    logic              pcLoad;
    logic              pcInc;
    logic              capture;
    logic              release_;

    assign target = redirect_pc & ~ADDR_W'(3);

    ifu_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) uPc (
        .clk      (clk),
        .rst      (rst),
        .load     (pcLoad),
        .loadAddr (target),
        .inc      (pcInc),
        .pc       (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            kill  <= 1'b0;
        end else begin
            state <= stateNext;
            if (killSet) begin
                kill <= 1'b1;
            end else if (killClr) begin
                kill <= 1'b0;
            end
        end
    end

    always_comb begin
        stateNext = state;
        pcLoad    = 1'b0;
        pcInc     = 1'b0;
        killSet   = 1'b0;
        killClr   = 1'b0;
        capture   = 1'b0;
        release_  = 1'b0;
        unique case (state)
            IDLE: stateNext = REQ;
            REQ: begin
                if (imem_req_ready) stateNext = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill || redirect_valid) begin
                        stateNext = REQ;
                        killClr   = 1'b1;
                    end else begin
                        stateNext = HOLD;
                        capture   = 1'b1;
                        pcInc     = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (instr_ready || redirect_valid) begin
                    stateNext = REQ;
                    release_  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        // A request still in flight after a redirect must be discarded on arrival.
        if (redirect_valid) begin
            pcLoad = 1'b1;
            if ((state == REQ && imem_req_ready) ||
                (state == WAIT && !imem_rsp_valid)) begin
                killSet = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else if (capture) begin
            instr_valid <= 1'b1;
            instr       <= imem_rsp_data;
            instr_pc    <= pc;
        end else if (release_) begin
            instr_valid <= 1'b0;
        end
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = imem_req_valid ? pc : '0;
    assign op             = instr[OP_MSB:OP_LSB];

`ifdef IFU_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (redirect_valid) begin
            stall_cycles <= '0;
        end else if (instr_valid && !instr_ready &&
                     stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (vector table + scoreboard).
// Build with +define+IFU_STALL_CNT_EN to also check stall_cycles.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          reqStall;
        int          rspDelay;
        int          hold;
        logic [31:0] expPc;
        logic [5:0]  expOp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic [5:0]  op;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        reqValid, reqReady;
    logic [31:0] reqAddr;
    logic        rspValid;
    logic [31:0] rspData;
    logic        instrValid, instrReady;
    logic [31:0] instr, instrPc;
    logic [5:0]  op;
    logic        redirValid;
    logic [31:0] redirPc;

    logic        wRst;
    logic        wReqValid, wReqReady;
    logic [31:0] wReqAddr;
    logic        wRspValid;
    logic [31:0] wRspData;
    logic        wInstrValid, wInstrReady;
    logic [31:0] wInstr, wInstrPc;
    logic [5:0]  wOp;
    logic        wRedirValid;
    logic [31:0] wRedirPc;

`ifdef IFU_STALL_CNT_EN
    logic [31:0] stallCycles;
    logic [31:0] wStallCycles;
`endif

    int nVec = 0;
    int nMis = 0;
    int expStall = 0;
    sb_t sb[$];
    vec_t vecs[7];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (reqValid),
        .imem_req_ready (reqReady),
        .imem_req_addr  (reqAddr),
        .imem_rsp_valid (rspValid),
        .imem_rsp_data  (rspData),
        .instr_valid    (instrValid),
        .instr_ready    (instrReady),
        .instr          (instr),
        .instr_pc       (instrPc),
        .op             (op),
`ifdef IFU_STALL_CNT_EN
        .stall_cycles   (stallCycles),
`endif
        .redirect_valid (redirValid),
        .redirect_pc    (redirPc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk            (clk),
        .rst            (wRst),
        .imem_req_valid (wReqValid),
        .imem_req_ready (wReqReady),
        .imem_req_addr  (wReqAddr),
        .imem_rsp_valid (wRspValid),
        .imem_rsp_data  (wRspData),
        .instr_valid    (wInstrValid),
        .instr_ready    (wInstrReady),
        .instr          (wInstr),
        .instr_pc       (wInstrPc),
        .op             (wOp),
`ifdef IFU_STALL_CNT_EN
        .stall_cycles   (wStallCycles),
`endif
        .redirect_valid (wRedirValid),
        .redirect_pc    (wRedirPc)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReq(output logic [31:0] a, output bit ok);
        ok = 1'b0;
        a  = '0;
        for (int i = 0; i < 20; i++) begin
            if (reqValid) begin
                ok = 1'b1;
                a  = reqAddr;
                break;
            end
            step();
        end
    endtask

    task automatic expectReq(input string name, input logic [31:0] exp);
        logic [31:0] a;
        bit ok;
        waitReq(a, ok);
        check({name, "Seen"}, 64'(ok), 64'd1);
        check(name, a, exp);
    endtask

    task automatic checkStall();
`ifdef IFU_STALL_CNT_EN
        check("stallCycles", stallCycles, 64'(expStall));
`endif
    endtask

    task automatic fetchVec(input vec_t v);
        sb_t e;
        reqReady = (v.reqStall == 0);
        expectReq("reqAddr", v.expPc);
        sb.push_back('{data: v.data, pc: v.expPc, op: v.expOp});
        for (int i = 0; i < v.reqStall; i++) begin
            step();
            check("reqHeld", {reqValid, reqAddr}, {1'b1, v.expPc});
        end
        reqReady = 1'b1;
        step();
        check("noReqInWait", 64'(reqValid), 64'd0);
        repeat (v.rspDelay) step();
        rspValid = 1'b1;
        rspData  = v.data;
        step();
        rspValid = 1'b0;
        rspData  = '0;
        check("instrValid", 64'(instrValid), 64'd1);
        for (int i = 0; i < v.hold; i++) begin
            step();
            check("holdStable", {instrValid, reqValid, instr},
                  {1'b1, 1'b0, v.data});
        end
        expStall += v.hold;
        checkStall();
        if (sb.size() == 0) begin
            check("sbEmpty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("instr", instr, e.data);
            check("instrPc", instrPc, e.pc);
            check("op", 64'(op), 64'(e.op));
        end
        instrReady = 1'b1;
        step();
        instrReady = 1'b0;
        check("consumed", 64'(instrValid), 64'd0);
    endtask

    task automatic redirWait();
        expectReq("killedReq", 32'h0000_000C);
        step();
        redirValid = 1'b1;
        redirPc    = 32'h0000_0103;
        step();
        redirValid = 1'b0;
        expStall   = 0;
        checkStall();
        step();
        rspValid = 1'b1;
        rspData  = 32'h8C00_0000;
        step();
        rspValid = 1'b0;
        check("staleDropped", 64'(instrValid), 64'd0);
    endtask

    task automatic redirRsp();
        expectReq("rspRaceReq", 32'h0000_0108);
        step();
        rspValid   = 1'b1;
        rspData    = 32'h0800_0000;
        redirValid = 1'b1;
        redirPc    = 32'h0000_0200;
        step();
        rspValid   = 1'b0;
        redirValid = 1'b0;
        expStall   = 0;
        check("raceNoValid", 64'(instrValid), 64'd0);
        check("raceReq", {reqValid, reqAddr}, {1'b1, 32'h0000_0200});
    endtask

    task automatic redirHold();
        expectReq("holdReq", 32'h0000_0204);
        step();
        rspValid = 1'b1;
        rspData  = 32'h1234_5678;
        step();
        rspValid = 1'b0;
        check("holdValid", 64'(instrValid), 64'd1);
        redirValid = 1'b1;
        redirPc    = 32'h0000_0300;
        step();
        redirValid = 1'b0;
        expStall   = 0;
        check("holdRedirDrop", 64'(instrValid), 64'd0);
        checkStall();
    endtask

    initial begin
        vecs[0] = '{32'h0000_0020, 0, 0, 0, 32'h0000_0000, OP_RTYPE};
        vecs[1] = '{32'h8C22_0004, 0, 2, 5, 32'h0000_0004, OP_LW};
        vecs[2] = '{32'h0800_0040, 3, 1, 0, 32'h0000_0008, OP_J};
        vecs[3] = '{32'hFC00_0001, 0, 0, 1, 32'h0000_0100, 6'h3F};
        vecs[4] = '{32'h2000_0005, 1, 0, 0, 32'h0000_0104, 6'h08};
        vecs[5] = '{32'h0000_0000, 0, 1, 2, 32'h0000_0200, OP_RTYPE};
        vecs[6] = '{32'hAC00_0010, 0, 0, 0, 32'h0000_0300, 6'h2B};

        rst = 1'b1; reqReady = 1'b1; rspValid = 1'b0; rspData = '0;
        instrReady = 1'b0; redirValid = 1'b0; redirPc = '0;
        wRst = 1'b1; wReqReady = 1'b1; wRspValid = 1'b0; wRspData = '0;
        wInstrReady = 1'b0; wRedirValid = 1'b0; wRedirPc = '0;

        repeat (3) step();
        check("rstOutputs", {reqValid, reqAddr, instrValid, instr, op},
              '0);
        check("rstInstrPc", instrPc, 64'd0);
        rst = 1'b0;
        check("noReqAtRelease", 64'(reqValid), 64'd0);
        step();
        check("firstReq", {reqValid, reqAddr}, {1'b1, 32'h0});
        checkStall();

        for (int i = 0; i < 7; i++) begin
            if (i == 3) redirWait();
            if (i == 5) redirRsp();
            if (i == 6) redirHold();
            fetchVec(vecs[i]);
        end

        expectReq("rstReq", 32'h0000_0304);
        step();
        #2 rst = 1'b1;
        #1;
        check("asyncRst", {reqValid, reqAddr, instrValid, instr, op},
              '0);
        check("asyncRstPc", instrPc, 64'd0);
        step();
        step();
        rst = 1'b0;
        expStall = 0;
        checkStall();
        check("idleAfterRst", 64'(reqValid), 64'd0);
        rspValid = 1'b1;
        rspData  = 32'hDEAD_BEEF;
        step();
        rspValid = 1'b0;
        check("lateRspIgnored", 64'(instrValid), 64'd0);
        check("reqAfterRst", {reqValid, reqAddr}, {1'b1, 32'h0});
        step();
        rspValid = 1'b1;
        rspData  = 32'h0000_0020;
        step();
        rspValid = 1'b0;
        check("recoverInstr", {instrValid, instr, instrPc},
              {1'b1, 32'h0000_0020, 32'h0});
        instrReady = 1'b1;
        step();
        instrReady = 1'b0;

        wRst = 1'b0;
        step();
        check("wrapFirstReq", {wReqValid, wReqAddr},
              {1'b1, 32'hFFFF_FFFC});
        step();
        wRspValid = 1'b1;
        wRspData  = 32'h8C00_0000;
        step();
        wRspValid = 1'b0;
        check("wrapInstr", {wInstrValid, wInstrPc, 26'd0, wOp},
              {1'b1, 32'hFFFF_FFFC, 26'd0, OP_LW});
        wInstrReady = 1'b1;
        step();
        wInstrReady = 1'b0;
        check("wrapSecondReq", {wReqValid, wReqAddr},
              {1'b1, 32'h0000_0000});

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
